// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and frame constants for the TX/RX units.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  // Serializer states; the encoding is fixed so both UART units agree.
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // 8N1 framing: 8 data bits, one start bit and one stop bit.
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage
`default_nettype wire

// File: rtl/uart_tx_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_unit_if
//  Description : CPU-side byte write interface of the UART transmit unit.
//                The CPU (master) strobes bytes in; the unit (slave) reports
//                FIFO full.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_unit_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] uart_tx_data;
  logic                      uart_wr_en;
  logic                      full;

  modport master (
    output uart_tx_data,
    output uart_wr_en,
    input  full
  );

  modport slave (
    input  uart_tx_data,
    input  uart_wr_en,
    output full
  );

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through read data.
//                Writes while full are dropped even if a pop happens in the
//                same cycle. DEPTH must be a power of two, >= 2.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             wr_ok;
  logic             rd_ok;

  // A full FIFO refuses the write regardless of a same-cycle pop.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rptr_q];

  // Occupancy next-state: unchanged on simultaneous push and pop.
  always_comb begin
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // Pointers and count; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (wr_ok) wptr_q <= wptr_q + 1'b1;
      if (rd_ok) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_unit.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_unit
//  Description : UART transmitter. Bytes from the CPU are queued in a
//                sync_fifo and serialised as 8N1 frames on txd. Frames run
//                back-to-back while the FIFO has data.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  uart_tx_unit_if.slave    bus,
  output logic             txd,
  output logic             busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                    state_q;
  logic [BAUD_W-1:0]            baud_q;
  logic [IDX_W-1:0]             bit_idx_q;
  logic [UART_DATA_BITS-1:0]    shreg_q;
  logic                         txd_q;

  logic [UART_DATA_BITS-1:0]    fifo_rdata;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [$clog2(FIFO_DEPTH):0]  fifo_count;
  logic                         baud_last;
  logic                         pop;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .wr_en (bus.uart_wr_en),
    .wdata (bus.uart_tx_data),
    .rd_en (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bus.full  = fifo_full;
  assign baud_last = (baud_q == BAUD_LAST);

  // Pop from IDLE, or on the last stop-bit cycle so the next frame follows
  // with no idle gap. FWFT data is loaded into shreg_q at the same edge.
  assign pop = !fifo_empty &&
               ((state_q == TX_IDLE) || ((state_q == TX_STOP) && baud_last));

  assign txd  = txd_q;
  assign busy = (state_q != TX_IDLE) || (fifo_count != '0);

  // Serializer FSM; txd_q is loaded with the level of the state being entered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= TX_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        TX_IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
          if (!fifo_empty) begin
            shreg_q <= fifo_rdata;
            state_q <= TX_START;
            txd_q   <= 1'b0;
          end
        end
        TX_START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= TX_DATA;
            txd_q     <= shreg_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_DATA: begin
          if (baud_last) begin
            baud_q    <= '0;
            shreg_q   <= shreg_q >> 1;
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == IDX_LAST) begin
              state_q <= TX_STOP;
              txd_q   <= 1'b1;
            end else begin
              txd_q <= shreg_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        TX_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shreg_q <= fifo_rdata;
              state_q <= TX_START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= TX_IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= TX_IDLE;
          baud_q  <= '0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_unit
//  Description : Self-checking bench for uart_tx_unit (CLKS_PER_BIT=4,
//                FIFO_DEPTH=4). Accepted bytes go to a scoreboard queue and
//                are matched against frames decoded from txd.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_unit;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // {stop, data[7:0], start}; bit 0 goes out first
  } vec_t;

  logic clk;
  logic rstn;
  logic txd;
  logic busy;
  int   cyc;
  int   n_checks;
  int   n_fail;
  logic [7:0] sb[$];

  uart_tx_unit_if bus();

  uart_tx_unit #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .txd  (txd),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc equals the index of the most recent rising edge
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; the write lands on the next edge, whose
  // index is returned in t. wr_en stays high so writes can be chained.
  task automatic wr(input logic [7:0] d, input bit exp_full, output int t);
    bus.uart_tx_data = d;
    bus.uart_wr_en   = 1'b1;
    @(negedge clk);
    check("full_before_write", bus.full, exp_full);
    @(posedge clk);
    #1;
    t = cyc;
    if (!exp_full) sb.push_back(d);
  endtask

  function automatic logic [39:0] expand(input logic [9:0] f);
    logic [39:0] s;
    for (int k = 0; k < 40; k++) s[k] = f[k / CPB];
    return s;
  endfunction

  // Returns {frame_ok, byte}: every bit stable for CPB samples, start 0, stop 1.
  function automatic logic [8:0] decode(input logic [39:0] s);
    logic       ok;
    logic [7:0] b;
    ok = 1'b1;
    for (int k = 0; k < 10; k++)
      for (int j = 1; j < CPB; j++)
        if (s[CPB*k+j] !== s[CPB*k]) ok = 1'b0;
    if (s[0] !== 1'b0 || s[9*CPB] !== 1'b1) ok = 1'b0;
    for (int k = 0; k < 8; k++) b[k] = s[CPB*(k+1)];
    return {ok, b};
  endfunction

  // Waits (bounded) for a start bit at falling edges, then grabs a full frame.
  task automatic rx_frame(input int budget, output logic [39:0] smp, output int t_start, output bit got);
    int waited;
    waited  = 0;
    got     = 1'b0;
    smp     = '1;
    t_start = -1;
    while (waited < budget && !got) begin
      @(negedge clk);
      if (txd === 1'b0) got = 1'b1;
      else waited++;
    end
    if (got) begin
      t_start = cyc;
      smp[0]  = 1'b0;
      for (int i = 1; i < FRAME; i++) begin
        @(negedge clk);
        smp[i] = txd;
      end
    end
  endtask

  task automatic rx_check(input string tag, output int ts);
    logic [39:0] smp;
    bit          got;
    logic [7:0]  e;
    rx_frame(200, smp, ts, got);
    check({tag, "_frame_seen"}, got, 1);
    check({tag, "_sb_has_entry"}, sb.size() > 0, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_byte"}, decode(smp), {1'b1, e});
    end
  endtask

  initial begin
    vec_t        tbl[5];
    logic [39:0] smp;
    int          t, t0, ts, ts1, ts2;
    bit          got;

    tbl[0] = '{data: 8'h55, frame: 10'b1_01010101_0};
    tbl[1] = '{data: 8'h00, frame: 10'b1_00000000_0};
    tbl[2] = '{data: 8'hFF, frame: 10'b1_11111111_0};
    tbl[3] = '{data: 8'h81, frame: 10'b1_10000001_0};
    tbl[4] = '{data: 8'h3C, frame: 10'b1_00111100_0};

    n_checks = 0;
    n_fail   = 0;
    rstn     = 1'b0;
    bus.uart_wr_en   = 1'b0;
    bus.uart_tx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_txd", txd, 1);
    check("reset_busy", busy, 0);
    check("reset_full", bus.full, 0);

    // Idle line for 100 cycles
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", txd, 1);
      check("idle_busy", busy, 0);
    end

    // Single-byte frames: start bit after edge T+1, busy drops after edge T+41
    for (int i = 0; i < 5; i++) begin
      sync();
      wr(tbl[i].data, 1'b0, t);
      bus.uart_wr_en = 1'b0;
      rx_frame(20, smp, ts, got);
      check("tbl_start_latency", ts, t + 1);
      check("tbl_frame_bits", smp, expand(tbl[i].frame));
      check("tbl_sb_has_entry", sb.size() > 0, 1);
      if (sb.size() > 0) check("tbl_byte", decode(smp), {1'b1, sb.pop_front()});
      check("tbl_busy_in_stop", busy, 1);
      @(negedge clk);
      check("tbl_busy_fall", busy, 0);
      check("tbl_txd_idle", txd, 1);
    end

    // Back-to-back: two contiguous frames
    sync();
    fork
      begin
        wr(8'hA5, 1'b0, t);
        wr(8'h3C, 1'b0, t);
        bus.uart_wr_en = 1'b0;
      end
      begin
        rx_check("b2b_first", ts1);
        rx_check("b2b_second", ts2);
      end
    join
    check("b2b_no_gap", ts2, ts1 + FRAME);
    @(negedge clk);
    check("b2b_busy_fall", busy, 0);

    // Overflow, then a dropped write at the STOP->START pop edge
    sync();
    fork
      begin
        wr(8'h01, 1'b0, t0);
        wr(8'h02, 1'b0, t);
        wr(8'h03, 1'b0, t);
        wr(8'h04, 1'b0, t);
        wr(8'h05, 1'b0, t);
        wr(8'h06, 1'b1, t);
        bus.uart_wr_en = 1'b0;
        @(negedge clk);
        check("ovf_full_held", bus.full, 1);
        while (cyc != t0 + FRAME) sync();
        wr(8'h77, 1'b1, t);
        bus.uart_wr_en = 1'b0;
        check("pushpop_edge", t, t0 + FRAME + 1);
        @(negedge clk);
        check("pushpop_full_drops", bus.full, 0);
      end
      begin
        rx_check("ovf_b1", ts);
        rx_check("ovf_b2", ts);
        rx_check("ovf_b3", ts);
        rx_check("ovf_b4", ts);
        rx_check("ovf_b5", ts);
        rx_frame(60, smp, ts, got);
        check("ovf_no_extra_frame", got, 0);
      end
    join
    check("ovf_sb_drained", sb.size(), 0);

    // Reset during DATA bit 3 of 0x00 while the FIFO is full
    sync();
    wr(8'h00, 1'b0, t0);
    wr(8'h11, 1'b0, t);
    wr(8'h22, 1'b0, t);
    wr(8'h33, 1'b0, t);
    wr(8'h44, 1'b0, t);
    bus.uart_wr_en = 1'b0;
    while (cyc != t0 + 18) sync();
    @(negedge clk);
    check("rst_pre_full", bus.full, 1);
    check("rst_pre_txd_data", txd, 0);
    check("rst_pre_busy", busy, 1);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_txd", txd, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_full", bus.full, 0);
    rstn = 1'b1;
    sb.delete();
    sync();
    wr(8'hFF, 1'b0, t);
    bus.uart_wr_en = 1'b0;
    rx_check("post_rst", ts);
    check("post_rst_latency", ts, t + 1);
    rx_frame(60, smp, ts, got);
    check("post_rst_no_extra_frame", got, 0);
    check("post_rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_unit.md
# uart_tx_unit

Transmit-side UART block that accepts bytes from the CPU core's memory stage over the `uart_tx_data`/`uart_wr_en`/`full` interface and serialises them onto the board TX pin. It contains a synchronous byte FIFO that decouples CPU stores from line rate, and an 8N1 serializer that drains the FIFO. It sits at the top level between `cpu` and the `txd` pin, and mirrors the receive unit that feeds the CPU.

## Interface
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 2.
- `FIFO_DEPTH`, 16: FIFO entries; must be a power of two and ≥ 2.

- `clk`  in  1  clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `uart_tx_data`  in  8  byte to enqueue; sampled when `uart_wr_en`=1.
- `uart_wr_en`  in  1  enqueue strobe, one byte per cycle.
- `full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  serializer is not idle, or the FIFO is non-empty.

## Operation
- **Write rule:** when `uart_wr_en`=1 and `full`=0, the byte is written at the clock edge.
  - When `uart_wr_en`=1 and `full`=1, the byte is dropped, even if the serializer pops in the same cycle.
  - The FIFO state is unchanged after a dropped write.
- **`full`:** combinational from the occupancy count (count == `FIFO_DEPTH`).
- **Pointers:** read/write pointers are log2(`FIFO_DEPTH`) bits and wrap naturally. Count is log2(`FIFO_DEPTH`)+1 bits.
- **Simultaneous push and pop:** count is unchanged, and both pointers advance.
- **Frame format:** 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1). Each bit is held for exactly `CLKS_PER_BIT` cycles.
- **States:**
  - IDLE: `txd`=1. If count≠0, pop the FIFO head into the shift register and go to START.
  - START: `txd`=0. Hold for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `txd`=shreg[0]. At the end of each bit, shift right and increment the index. After index 7 completes, go to STOP.
  - STOP: `txd`=1. On the last cycle of the stop bit, if count≠0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Baud counter:** counts 0..`CLKS_PER_BIT`-1 and clears on every state change.
- **`txd` source:** driven from a register, so it is glitch-free.
- **`busy`:** busy = (state≠IDLE) || (count≠0).

## Timing
- **Reset values:** `txd`=1, `full`=0, `busy`=0, state IDLE, pointers/count/baud counter/bit index all 0. FIFO contents are discarded.
- **Reset mid-frame:** the frame is aborted, and `txd` is high in the cycle after the reset edge.
- **Latency:** a byte written at edge T into an empty FIFO with IDLE serializer is popped at edge T+1. `txd` goes low after edge T+1, i.e. 2 cycles after the write strobe.
- **Frame length:** 10·`CLKS_PER_BIT` cycles per frame. Back-to-back frames have no gap, so N queued bytes take exactly 10·N·`CLKS_PER_BIT` cycles of line time.
- **`full` updates:** `full` asserts in the cycle after the write that fills the FIFO, and deasserts in the cycle after the next pop.
  - The CPU must sample `full` before strobing.
  - A strobe in the same cycle that `full` rises is dropped.

## Structure
- **`uart_pkg`:** holds `typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;` and the frame constants (`UART_DATA_BITS`=8, `UART_FRAME_BITS`=10).
- **Sub-module `sync_fifo`:**
  - Parameters: width, depth.
  - Ports: `clk`, `rstn`, `wr_en`, `wdata`, `rd_en`, `rdata`, `full`, `empty`, `count`.
  - `rdata` is first-word-fall-through (shows the head combinationally), so the pop and the shift-register load happen at the same edge.
  - This module is reused by the RX unit.
- **Top-level contents:** `uart_tx_unit` instantiates `sync_fifo` and holds the state machine, baud counter, bit index and shift register.

## Test plan
Use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4 in simulation.
- **Single byte:** write 0x55 at edge T → `txd` low from T+2 for 4 cycles, then bits 1,0,1,0,1,0,1,0 (4 cycles each), then high. `busy` falls at T+42.
- **Back-to-back:** write 0xA5 and 0x3C on consecutive cycles → two contiguous 40-cycle frames with no idle cycle between them. Decoded bytes are 0xA5 then 0x3C.
- **Overflow:**
  - Write 0x01..0x06 on 6 consecutive cycles. The first is popped at T+1, so the FIFO holds 0x02..0x05 and `full`=1.
  - 0x06 is dropped.
  - Line output is 0x01..0x05 only.
- **Simultaneous push/pop:** with the FIFO full, pop at the STOP→START edge while strobing a write → write dropped, count becomes 3, and `full` deasserts on the next cycle.
- **Reset mid-frame:** assert `rstn`=0 during DATA bit 3 of 0x00 → `txd`=1, `busy`=0, `full`=0 the next cycle. A subsequent write of 0xFF produces one clean frame.
- **Idle line:** after reset with no writes for 100 cycles → `txd` stays 1 and `busy` stays 0 throughout.
